// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit MEM-stage load or store into two 16-bit
// accesses on an asynchronous SRAM. The low half-word goes first, then the
// high half-word. Each half takes WAIT_CYCLES clocks.
//
// Handshake: ready is combinational. It is high in DONE, and in IDLE when no
// request is present. While ready is low, the requester holds rd_en, wr_en,
// address and write_data stable. A request is accepted on the clock edge that
// leaves IDLE. The request type and the word index are latched on that edge.
// From then on the access uses only the latched copies.
//
// All SRAM pins are registered. They are computed from the next state, so
// they are already valid in the first cycle of LO and HI.
//
// WAIT_CYCLES must be in the range 2..15. The counter is 4 bits wide, and the
// write strobe needs at least one low cycle followed by a hold cycle.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_dq_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last counter value of a half access.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
  // Last counter value with the write strobe low. The final cycle holds data.
  localparam logic [3:0] WE_LAST  = 4'(WAIT_CYCLES - 2);

  // Registered state.
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_idx;
  logic [31:0] r_read_data;
  logic [17:0] r_sram_addr;
  logic        r_we_n;
  logic        r_oe_n;
  logic        r_dq_oe;
  logic [15:0] r_dq_out;

  // Next-state values.
  state_t      w_nxt_state;
  logic [3:0]  w_nxt_cnt;
  logic        w_nxt_is_wr;
  logic [16:0] w_nxt_idx;

  // Request decode.
  logic        w_req;
  logic [31:0] w_offset;
  logic [16:0] w_req_idx;

  assign w_req     = rd_en | wr_en;
  // The subtraction wraps, so addresses below BASE_ADDR land at the top of
  // the 2^17-word space. Byte-lane bits [1:0] are dropped by the shift.
  assign w_offset  = address - BASE_ADDR;
  assign w_req_idx = 17'(w_offset >> 2);

  // ready is combinational, so the pipeline can advance in the same cycle.
  assign ready = (r_state == DONE) || ((r_state == IDLE) && !w_req);

  // The chip is always selected, and both byte lanes are always enabled.
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign SRAM_DQ     = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_OE_N   = r_oe_n;
  assign read_data   = r_read_data;
  assign o_dbg_state = r_state;
  assign o_dbg_dq_oe = r_dq_oe;

  // Next state, cycle counter and request latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_is_wr = r_is_wr;
    w_nxt_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_nxt_state = LO;
          w_nxt_cnt   = 4'd0;
          // When both requests are present, the access is a write.
          w_nxt_is_wr = wr_en;
          w_nxt_idx   = w_req_idx;
        end
      end
      LO: begin
        if (r_cnt == LAST_CNT) begin
          w_nxt_state = HI;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      HI: begin
        if (r_cnt == LAST_CNT) begin
          w_nxt_state = DONE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = 4'd0;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  // FSM register.
  // SRAM pins are decoded from the next state.
  // Read halves are captured on the final cycle of LO and of HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_idx       <= 17'd0;
      r_read_data <= 32'd0;
      r_sram_addr <= 18'd0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= 16'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_is_wr <= w_nxt_is_wr;
      r_idx   <= w_nxt_idx;

      // Bus idle values, overridden below inside an access.
      r_sram_addr <= 18'd0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= 16'd0;

      if ((w_nxt_state == LO) || (w_nxt_state == HI)) begin
        r_sram_addr <= {w_nxt_idx, (w_nxt_state == HI)};
        if (w_nxt_is_wr) begin
          r_dq_oe  <= 1'b1;
          r_dq_out <= (w_nxt_state == HI) ? write_data[31:16] : write_data[15:0];
          // The strobe is low for the early cycles and high on the last
          // cycle, which gives data hold time before the address moves.
          r_we_n   <= (w_nxt_cnt > WE_LAST);
        end else begin
          r_oe_n <= 1'b0;
        end
      end

      if (!r_is_wr && (r_cnt == LAST_CNT)) begin
        if (r_state == LO) begin
          r_read_data[15:0] <= SRAM_DQ;
        end
        if (r_state == HI) begin
          r_read_data[31:16] <= SRAM_DQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller. One instance uses the default
// WAIT_CYCLES=3 and is backed by a behavioural SRAM. A second instance uses
// WAIT_CYCLES=2 and exercises the shortest legal timing.
module tb_sram_controller;

  localparam int W = 3;

  // Clock and reset.
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main instance signals.
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         we_n;
  wire         oe_n;
  wire         ce_n;
  wire         ub_n;
  wire         lb_n;
  wire  [1:0]  dbg_state;
  wire         dbg_dq_oe;

  // Instance with WAIT_CYCLES=2.
  logic        rd_en2;
  logic        wr_en2;
  logic [31:0] address2;
  logic [31:0] write_data2;
  wire  [31:0] read_data2;
  wire         ready2;
  wire  [15:0] sram_dq2;
  wire  [17:0] sram_addr2;
  wire         we_n2;
  wire         oe_n2;
  wire         ce_n2;
  wire         ub_n2;
  wire         lb_n2;
  wire  [1:0]  dbg_state2;
  wire         dbg_dq_oe2;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .SRAM_DQ     (sram_dq),
    .SRAM_ADDR   (sram_addr),
    .SRAM_WE_N   (we_n),
    .SRAM_OE_N   (oe_n),
    .SRAM_CE_N   (ce_n),
    .SRAM_UB_N   (ub_n),
    .SRAM_LB_N   (lb_n),
    .o_dbg_state (dbg_state),
    .o_dbg_dq_oe (dbg_dq_oe)
  );

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en2),
    .wr_en       (wr_en2),
    .address     (address2),
    .write_data  (write_data2),
    .read_data   (read_data2),
    .ready       (ready2),
    .SRAM_DQ     (sram_dq2),
    .SRAM_ADDR   (sram_addr2),
    .SRAM_WE_N   (we_n2),
    .SRAM_OE_N   (oe_n2),
    .SRAM_CE_N   (ce_n2),
    .SRAM_UB_N   (ub_n2),
    .SRAM_LB_N   (lb_n2),
    .o_dbg_state (dbg_state2),
    .o_dbg_dq_oe (dbg_dq_oe2)
  );

  // Behavioural SRAM on the main bus. It drives DQ while OE_N=0 and WE_N=1.
  // It stores data on the rising edge of WE_N.
  logic [15:0] mem [logic [17:0]];
  logic [15:0] dq_drv;

  assign sram_dq = (!oe_n && we_n) ? dq_drv : 16'hzzzz;

  always @(negedge clk) begin
    dq_drv = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;
  end

  always @(posedge we_n) begin
    if (!rst) mem[sram_addr] = sram_dq;
  end

  // Scoreboard counters.
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current cycle (cycle 0). Then checks the bus
  // cycle by cycle through DONE, and drops the request in DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [16:0] idx,
                            input logic [31:0] exp_rd, input string name);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = data;
    #1;
    chk($sformatf("%s_c0_ready", name), 32'(ready), 32'd0);
    for (int c = 1; c <= 2 * W; c++) begin
      bit hi;
      int k;
      step();
      hi = (c > W);
      k  = hi ? c - W - 1 : c - 1;
      chk($sformatf("%s_c%0d_state", name, c), 32'(dbg_state), hi ? 32'd2 : 32'd1);
      chk($sformatf("%s_c%0d_addr", name, c), 32'(sram_addr), 32'({idx, hi}));
      chk($sformatf("%s_c%0d_ready", name, c), 32'(ready), 32'd0);
      if (wr) begin
        chk($sformatf("%s_c%0d_we_n", name, c), 32'(we_n), (k <= W - 2) ? 32'd0 : 32'd1);
        chk($sformatf("%s_c%0d_oe_n", name, c), 32'(oe_n), 32'd1);
        chk($sformatf("%s_c%0d_dq_oe", name, c), 32'(dbg_dq_oe), 32'd1);
        chk($sformatf("%s_c%0d_dq", name, c), 32'(sram_dq), hi ? 32'(data[31:16]) : 32'(data[15:0]));
      end else begin
        chk($sformatf("%s_c%0d_we_n", name, c), 32'(we_n), 32'd1);
        chk($sformatf("%s_c%0d_oe_n", name, c), 32'(oe_n), 32'd0);
        chk($sformatf("%s_c%0d_dq_oe", name, c), 32'(dbg_dq_oe), 32'd0);
      end
    end
    step();
    chk($sformatf("%s_done_ready", name), 32'(ready), 32'd1);
    chk($sformatf("%s_done_state", name), 32'(dbg_state), 32'd3);
    chk($sformatf("%s_done_addr", name), 32'(sram_addr), 32'd0);
    chk($sformatf("%s_done_we_n", name), 32'(we_n), 32'd1);
    chk($sformatf("%s_done_oe_n", name), 32'(oe_n), 32'd1);
    chk($sformatf("%s_done_rdata", name), read_data, exp_rd);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    address     = 32'd0;
    write_data  = 32'd0;
    rd_en2      = 1'b0;
    wr_en2      = 1'b0;
    address2    = 32'd0;
    write_data2 = 32'd0;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_oe", 32'(dbg_dq_oe), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'd0);
    step();
    step();
    rst = 1'b0;

    mem[18'h00006] = 16'h1111;
    mem[18'h00007] = 16'h2222;
    mem[18'h3FFFE] = 16'hCAFE;
    mem[18'h3FFFF] = 16'hF00D;

    // Write, then read back at the base address.
    step(); run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, 32'd0, "wr1");
    chk("mem_lo_half", 32'(mem[18'd0]), 32'h0000BEEF);
    chk("mem_hi_half", 32'(mem[18'd1]), 32'h0000DEAD);
    step(); run_access(1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 32'hDEADBEEF, "rd1");

    // Address mapping, wrap below the base address, and ignored low bits.
    step(); run_access(1'b1, 1'b0, 32'd1036, 32'd0, 17'd3, 32'h22221111, "rd_map");
    step(); run_access(1'b1, 1'b0, 32'd1020, 32'd0, 17'h1FFFF, 32'hF00DCAFE, "rd_wrap");
    step(); run_access(1'b1, 1'b0, 32'd1027, 32'd0, 17'd0, 32'hDEADBEEF, "rd_lowbits");

    // A simultaneous read and write request is performed as a write.
    step(); run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, 17'd2, 32'hDEADBEEF, "rdwr");
    step();
    chk("rdwr_idle_rdata", read_data, 32'hDEADBEEF);
    chk("rdwr_idle_ready", 32'(ready), 32'd1);
    step(); run_access(1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, 32'h12345678, "rdwr_back");

    // Reset in cycle 2 of a write, then restart with the request held.
    step();
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hAAAA5555;
    step();
    step();
    chk("abort_pre_we_n", 32'(we_n), 32'd0);
    chk("abort_pre_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_dq_oe", 32'(dbg_dq_oe), 32'd0);
    chk("abort_oe_n", 32'(oe_n), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    chk("abort_no_write", 32'(mem.exists(18'd8)), 32'd0);
    step();
    rst = 1'b0;
    run_access(1'b0, 1'b1, 32'd1040, 32'hAAAA5555, 17'd4, 32'd0, "wr_restart");
    step(); run_access(1'b1, 1'b0, 32'd1040, 32'd0, 17'd4, 32'hAAAA5555, "rd_restart");

    // Back-to-back: the write is presented in the cycle after DONE.
    step(); run_access(1'b1, 1'b0, 32'd1036, 32'd0, 17'd3, 32'h22221111, "b2b_rd");
    step(); run_access(1'b0, 1'b1, 32'd1044, 32'h0F0F1E1E, 17'd5, 32'h22221111, "b2b_wr");
    step(); run_access(1'b1, 1'b0, 32'd1044, 32'd0, 17'd5, 32'h0F0F1E1E, "b2b_back");

    // WAIT_CYCLES=2: two-cycle halves, one low strobe cycle, ready in cycle 5.
    step();
    wr_en2      = 1'b1;
    address2    = 32'd1024;
    write_data2 = 32'h0000FFFF;
    #1;
    chk("w2_c0_ready", 32'(ready2), 32'd0);
    step();
    chk("w2_c1_addr", 32'(sram_addr2), 32'd0);
    chk("w2_c1_we_n", 32'(we_n2), 32'd0);
    chk("w2_c1_dq", 32'(sram_dq2), 32'h0000FFFF);
    chk("w2_c1_oe_n", 32'(oe_n2), 32'd1);
    step();
    chk("w2_c2_we_n", 32'(we_n2), 32'd1);
    chk("w2_c2_dq", 32'(sram_dq2), 32'h0000FFFF);
    chk("w2_c2_ready", 32'(ready2), 32'd0);
    step();
    chk("w2_c3_addr", 32'(sram_addr2), 32'd1);
    chk("w2_c3_we_n", 32'(we_n2), 32'd0);
    chk("w2_c3_dq", 32'(sram_dq2), 32'h00000000);
    step();
    chk("w2_c4_we_n", 32'(we_n2), 32'd1);
    chk("w2_c4_ready", 32'(ready2), 32'd0);
    step();
    chk("w2_c5_ready", 32'(ready2), 32'd1);
    chk("w2_c5_state", 32'(dbg_state2), 32'd3);
    wr_en2 = 1'b0;
    step();
    chk("w2_idle_ready", 32'(ready2), 32'd1);
    chk("w2_idle_state", 32'(dbg_state2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 3, giving the cycles spent on each 16-bit half access; legal values are 2 to 15.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024, giving the byte address that maps to SRAM word 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rd_en, input, 1 bit: MEM-stage load request.
REQ-006 The block SHALL have port wr_en, input, 1 bit: MEM-stage store request.
REQ-007 The block SHALL have port address, input, 32 bits: byte address (ALU result).
REQ-008 The block SHALL have port write_data, input, 32 bits: store data (val_Rm).
REQ-009 The block SHALL have port read_data, output, 32 bits: registered load result.
REQ-010 The block SHALL have port ready, output, 1 bit: high means no access is outstanding; the pipeline freezes while ready=0.
REQ-011 The block SHALL have port SRAM_DQ, inout, 16 bits: external data bus.
REQ-012 The block SHALL have port SRAM_ADDR, output, 18 bits: external half-word address.
REQ-013 The block SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N and SRAM_LB_N, each output, 1 bit: active-low SRAM controls.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LO, HI, DONE.
REQ-015 IDLE with rd_en or wr_en asserted SHALL go to LO; otherwise the FSM SHALL stay in IDLE.
REQ-016 LO SHALL last WAIT_CYCLES cycles and then go to HI.
REQ-017 HI SHALL last WAIT_CYCLES cycles and then go to DONE.
REQ-018 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-019 A cycle counter SHALL clear to 0 on entry to LO and on entry to HI, and SHALL increment by 1 each cycle within the state.
REQ-020 ready SHALL be combinational:
- 1 in DONE;
- 1 in IDLE when rd_en=0 and wr_en=0;
- 0 in all other cases.
REQ-021 Request latency SHALL be as follows: with the request first seen in IDLE at cycle 0, ready SHALL be 1 in cycle 2*WAIT_CYCLES+1 (cycle 7 at the default).
REQ-022 The requester SHALL hold rd_en, wr_en, address and write_data stable while ready=0.
REQ-023 The block SHALL latch the request type and address on the IDLE->LO edge, and SHALL use only the latched copies from then on.
REQ-024 If rd_en=1 and wr_en=1 together, the access SHALL be a write, and read_data SHALL be unchanged.
REQ-025 Address mapping:
- idx = (address - BASE_ADDR)[18:2], 32-bit subtraction with wrap-around;
- SRAM_ADDR = {idx[16:0], 1'b0} in LO;
- SRAM_ADDR = {idx[16:0], 1'b1} in HI.
REQ-026 address[1:0] SHALL be ignored, and addresses below BASE_ADDR SHALL wrap modulo 2^17 words.
REQ-027 Write, LO state: SRAM_DQ = write_data[15:0].
REQ-028 Write, HI state: SRAM_DQ = write_data[31:16].
REQ-029 In write states, SRAM_WE_N SHALL be 0 for counter values 0 to WAIT_CYCLES-2 and 1 on the final cycle (data hold).
REQ-030 Read, LO state: SRAM_DQ SHALL be high-Z, SRAM_OE_N=0 and SRAM_WE_N=1.
REQ-031 Read, LO state: on the final LO cycle the block SHALL register read_data[15:0] <= SRAM_DQ.
REQ-032 Read, HI state: the bus and control settings of LO SHALL apply, and on the final HI cycle the block SHALL register read_data[31:16] <= SRAM_DQ.
REQ-033 Outside write states, SRAM_DQ SHALL be high-Z.
REQ-034 SRAM_OE_N SHALL be 1 except in read LO/HI.
REQ-035 SRAM_WE_N SHALL be 1 except as defined in REQ-029.
REQ-036 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be constant 0.
REQ-037 In IDLE and DONE, SRAM_ADDR SHALL be 0.
REQ-038 read_data SHALL hold its last value until the next read overwrites it.

Reset
REQ-039 When rst=1, asynchronously:
- state = IDLE, counter = 0, latched request cleared;
- read_data = 0;
- SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_ADDR = 0, SRAM_DQ high-Z.
REQ-040 ready SHALL follow REQ-020 during and after reset.
REQ-041 Reset mid-access SHALL abort the access without finishing the second half.
REQ-042 A request still held after reset release SHALL restart from LO.

Verification
REQ-043 Write then read (defaults):
- Stimulus: wr_en=1, address=1024, write_data=0xDEADBEEF.
- Response: SRAM_ADDR=0 with DQ=0xBEEF in cycles 1-3, SRAM_ADDR=1 with DQ=0xDEAD in cycles 4-6, ready=1 in cycle 7.
- Then rd_en=1 at 1024, with the SRAM model returning the stored halves.
- Response: read_data=0xDEADBEEF, ready=1 in cycle 7.
REQ-044 Address mapping:
- Stimulus: rd_en=1, address=1036.
- Response: SRAM_ADDR=6 in LO, 7 in HI.
- Stimulus: address=1020.
- Response: idx=0x1FFFF, SRAM_ADDR=0x3FFFE then 0x3FFFF.
REQ-045 Simultaneous request:
- Stimulus: rd_en=1 and wr_en=1, write_data=0x12345678.
- Response: write cycle, WE_N pulses low for cycles 1-2 and 4-5, read_data unchanged.
REQ-046 Reset mid-access:
- Stimulus: assert rst in cycle 2 of a write.
- Response: WE_N=1 and DQ high-Z immediately.
- Stimulus: release rst with wr_en held.
- Response: a full write restarts and ready=1 after 2*WAIT_CYCLES+1 cycles.
REQ-047 Back-to-back requests:
- Stimulus: read, then a write presented in the cycle after DONE.
- Response: ready=1 for exactly one cycle between the two accesses, and no half-access is skipped or repeated.
REQ-048 Parameter corner:
- Stimulus: WAIT_CYCLES=2, write 0x0000FFFF.
- Response: each half is 2 cycles with WE_N low for 1 cycle, and ready=1 in cycle 5.
